// File: rtl/viterbi_k3_codec.sv
// Rate-1/2, K=3 (7,5) convolutional encoder plus hard-decision Viterbi decoder.
// Independent encoder and decoder paths; the decoder keeps register-exchange survivors.
module viterbi_k3_codec #(
   parameter int unsigned TB_DEPTH = 16,
   parameter int unsigned PM_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enc_enable_i,
   input  logic       enc_d_i,
   output logic       enc_valid_o,
   output logic [1:0] enc_d_o,
   input  logic       dec_enable_i,
   input  logic [1:0] dec_d_i,
   output logic       dec_d_o,
   output logic       dec_valid_o
);

   localparam int unsigned SW = PM_W + 1;
   localparam int unsigned CW = (TB_DEPTH > 2) ? $clog2(TB_DEPTH) : 1;
   localparam logic [CW-1:0]   FILL_MAX = CW'(TB_DEPTH - 1);
   localparam logic [PM_W-1:0] PM_INIT  = PM_W'(32);

   // ---------------- encoder ----------------
   logic [1:0] enc_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enc_state   <= '0;
         enc_d_o     <= '0;
         enc_valid_o <= 1'b0;
      end else if (enc_enable_i) begin
         enc_d_o     <= {enc_d_i ^ enc_state[1] ^ enc_state[0], enc_d_i ^ enc_state[0]};
         enc_state   <= {enc_d_i, enc_state[1]};
         enc_valid_o <= 1'b1;
      end else begin
         enc_valid_o <= 1'b0;
      end
   end

   // ---------------- decoder ----------------
   logic [PM_W-1:0]     pm       [4];
   logic [TB_DEPTH-1:0] surv     [4];
   logic [CW-1:0]       fill_cnt;

   logic [1:0]          bm0      [4];
   logic [1:0]          bm1      [4];
   logic [SW-1:0]       cand0    [4];
   logic [SW-1:0]       cand1    [4];
   logic [SW-1:0]       acs_pm   [4];
   logic [TB_DEPTH-1:0] acs_surv [4];
   logic [PM_W-1:0]     norm_pm  [4];
   logic [SW-1:0]       min_pm;
   logic [1:0]          best;

   // Hamming distance between the received symbol and the branch label for (pred, u).
   function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] pred,
                                                input logic u);
      logic [1:0] exp_sym;
      logic [1:0] diff;
      exp_sym = {u ^ pred[1] ^ pred[0], u ^ pred[0]};
      diff    = rx ^ exp_sym;
      return {diff[1] & diff[0], diff[1] ^ diff[0]};
   endfunction

   always_comb begin
      for (int unsigned ns = 0; ns < 4; ns++) begin
         // ns = {u, a}; predecessors are {a,0} and {a,1}, tie keeps {a,0}
         bm0[ns]   = branch_metric(dec_d_i, {ns[0], 1'b0}, ns[1]);
         bm1[ns]   = branch_metric(dec_d_i, {ns[0], 1'b1}, ns[1]);
         cand0[ns] = {1'b0, pm[{ns[0], 1'b0}]} + SW'(bm0[ns]);
         cand1[ns] = {1'b0, pm[{ns[0], 1'b1}]} + SW'(bm1[ns]);
         if (cand1[ns] < cand0[ns]) begin
            acs_pm[ns]   = cand1[ns];
            acs_surv[ns] = {surv[{ns[0], 1'b1}][TB_DEPTH-2:0], ns[1]};
         end else begin
            acs_pm[ns]   = cand0[ns];
            acs_surv[ns] = {surv[{ns[0], 1'b0}][TB_DEPTH-2:0], ns[1]};
         end
      end

      min_pm = acs_pm[0];
      best   = 2'd0;
      for (int unsigned s = 1; s < 4; s++) begin
         if (acs_pm[s] < min_pm) begin
            min_pm = acs_pm[s];
            best   = 2'(s);
         end
      end

      for (int unsigned s = 0; s < 4; s++) begin
         norm_pm[s] = PM_W'(acs_pm[s] - min_pm);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pm[0] <= '0;
         pm[1] <= PM_INIT;
         pm[2] <= PM_INIT;
         pm[3] <= PM_INIT;
         for (int unsigned s = 0; s < 4; s++) begin
            surv[s] <= '0;
         end
         fill_cnt    <= '0;
         dec_d_o     <= 1'b0;
         dec_valid_o <= 1'b0;
      end else if (dec_enable_i) begin
         for (int unsigned s = 0; s < 4; s++) begin
            pm[s]   <= norm_pm[s];
            surv[s] <= acs_surv[s];
         end
         dec_d_o     <= acs_surv[best][TB_DEPTH-1];
         dec_valid_o <= (fill_cnt == FILL_MAX);
         if (fill_cnt != FILL_MAX) begin
            fill_cnt <= fill_cnt + 1'b1;
         end
      end else begin
         dec_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_viterbi_k3_codec.sv
// Directed and loopback bench for viterbi_k3_codec: encoder table, ACS arithmetic,
// reset behaviour, and encoder->register->decoder streams with and without bit errors.
module tb_viterbi_k3_codec;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enc_enable_i = 1'b0;
   logic       enc_d_i = 1'b0;
   logic       enc_valid_o;
   logic [1:0] enc_d_o;
   logic       dec_enable_i;
   logic [1:0] dec_d_i;
   logic       dec_d_o;
   logic       dec_valid_o;

   logic       direct = 1'b0;
   logic       dec_en_drv = 1'b0;
   logic [1:0] dec_d_drv = 2'b00;
   logic [1:0] sym_q;
   logic       sym_v;
   int         sym_cnt;
   logic       inject = 1'b0;

   int   errors = 0;
   int   checks = 0;
   logic sb_on = 1'b0;
   logic sb_q[$];
   int   out_cnt, acc_cnt, first_valid_acc;
   logic seen_valid, last_en, enc_last_en, prev_d;
   logic [1:0] prev_enc;
   string cur_tag = "";

   always #5 clk = ~clk;

   viterbi_k3_codec #(.TB_DEPTH(16), .PM_W(8)) dut (
      .clk(clk), .rst(rst),
      .enc_enable_i(enc_enable_i), .enc_d_i(enc_d_i),
      .enc_valid_o(enc_valid_o), .enc_d_o(enc_d_o),
      .dec_enable_i(dec_enable_i), .dec_d_i(dec_d_i),
      .dec_d_o(dec_d_o), .dec_valid_o(dec_valid_o)
   );

   // channel register with optional burst corruption of symbol bit 1
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sym_q <= 2'b00; sym_v <= 1'b0; sym_cnt <= 0;
      end else begin
         sym_v <= enc_valid_o;
         if (enc_valid_o) begin
            sym_q <= enc_d_o ^ ((inject && sym_cnt < 256 &&
                     (sym_cnt % 16 == 5 || sym_cnt % 16 == 6)) ? 2'b10 : 2'b00);
            sym_cnt <= sym_cnt + 1;
         end
      end
   end

   assign dec_enable_i = direct ? dec_en_drv : sym_v;
   assign dec_d_i      = direct ? dec_d_drv  : sym_q;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // scoreboard and hold monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (sb_on) begin
         if (dec_valid_o) begin
            if (!seen_valid) begin
               seen_valid = 1'b1;
               first_valid_acc = acc_cnt;
            end
            if (sb_q.size() == 0) begin
               check({cur_tag, "_sb_underflow"}, 1, 0);
            end else begin
               check({cur_tag, "_dec_bit"}, int'(dec_d_o), int'(sb_q.pop_front()));
               out_cnt++;
            end
         end
         if (!last_en) begin
            check({cur_tag, "_dec_valid_idle"}, int'(dec_valid_o), 0);
            check({cur_tag, "_dec_hold"}, int'(dec_d_o), int'(prev_d));
         end
         if (!enc_last_en) begin
            check({cur_tag, "_enc_valid_idle"}, int'(enc_valid_o), 0);
            check({cur_tag, "_enc_hold"}, int'(enc_d_o), int'(prev_enc));
         end
         prev_d      = dec_d_o;
         prev_enc    = enc_d_o;
         last_en     = dec_enable_i;
         enc_last_en = enc_enable_i;
         if (dec_enable_i) acc_cnt++;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      sb_on = 1'b0;
      enc_enable_i = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic drive_bit(input logic b);
      enc_enable_i = 1'b1;
      enc_d_i = b;
      if (sb_on) sb_q.push_back(b);
      step();
   endtask

   task automatic idle(input int n);
      enc_enable_i = 1'b0;
      repeat (n) step();
   endtask

   task automatic run_loop(input logic inj, input logic gaps, input string tag);
      do_reset();
      inject = inj; cur_tag = tag;
      sb_q.delete();
      out_cnt = 0; acc_cnt = 0; first_valid_acc = 0; seen_valid = 1'b0;
      last_en = 1'b0; enc_last_en = 1'b0; prev_d = 1'b0; prev_enc = 2'b00;
      sb_on = 1'b1;
      for (int i = 0; i < 271; i++) begin
         if (gaps && $urandom_range(0, 15) == 0) idle(3);
         drive_bit(i < 256 ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      idle(20);
      sb_on = 1'b0;
      inject = 1'b0;
      check({tag, "_out_count"}, out_cnt, 256);
      check({tag, "_first_valid_at"}, first_valid_acc, 16);
   endtask

   typedef struct {
      logic       en;
      logic       din;
      logic [1:0] exp_sym;
      logic       exp_v;
   } enc_vec_t;

   initial begin
      enc_vec_t   vec [8];
      logic [7:0] pmv [4];
      int         mn, mx;

      vec[0] = '{1'b1, 1'b1, 2'b11, 1'b1};
      vec[1] = '{1'b1, 1'b0, 2'b10, 1'b1};
      vec[2] = '{1'b1, 1'b1, 2'b00, 1'b1};
      vec[3] = '{1'b1, 1'b1, 2'b01, 1'b1};
      vec[4] = '{1'b1, 1'b0, 2'b01, 1'b1};
      vec[5] = '{1'b1, 1'b0, 2'b11, 1'b1};
      vec[6] = '{1'b0, 1'b1, 2'b11, 1'b0};   // disabled: symbol and state hold
      vec[7] = '{1'b1, 1'b0, 2'b00, 1'b1};   // state 00 proves the hold

      // reset state
      do_reset();
      check("rst_enc_d", int'(enc_d_o), 0);
      check("rst_enc_valid", int'(enc_valid_o), 0);
      check("rst_dec_d", int'(dec_d_o), 0);
      check("rst_dec_valid", int'(dec_valid_o), 0);
      check("rst_pm0", int'(dut.pm[0]), 0);
      check("rst_pm3", int'(dut.pm[3]), 32);

      // encoder vectors
      for (int i = 0; i < 8; i++) begin
         enc_enable_i = vec[i].en;
         enc_d_i = vec[i].din;
         step();
         check($sformatf("enc_vec%0d_sym", i), int'(enc_d_o), int'(vec[i].exp_sym));
         check($sformatf("enc_vec%0d_valid", i), int'(enc_valid_o), int'(vec[i].exp_v));
      end

      // ACS arithmetic and tie handling from reset
      do_reset();
      direct = 1'b1; dec_en_drv = 1'b1;
      dec_d_drv = 2'b11;
      step();
      pmv[0] = dut.pm[0]; pmv[1] = dut.pm[1]; pmv[2] = dut.pm[2]; pmv[3] = dut.pm[3];
      check("acs1_pm0", int'(pmv[0]), 2);
      check("acs1_pm1", int'(pmv[1]), 33);
      check("acs1_pm2", int'(pmv[2]), 0);
      check("acs1_pm3", int'(pmv[3]), 33);
      dec_d_drv = 2'b00;
      step();
      pmv[0] = dut.pm[0]; pmv[1] = dut.pm[1]; pmv[2] = dut.pm[2]; pmv[3] = dut.pm[3];
      check("acs2_pm0", int'(pmv[0]), 1);
      check("acs2_pm1", int'(pmv[1]), 0);
      check("acs2_pm2", int'(pmv[2]), 3);
      check("acs2_pm3", int'(pmv[3]), 0);
      check("acs2_surv1", int'(dut.surv[1]), 2);
      check("acs2_surv3", int'(dut.surv[3]), 3);

      // long 00 then 11 runs: best metric normalised to 0, spread stays small
      for (int i = 0; i < 80; i++) begin
         dec_d_drv = (i < 40) ? 2'b00 : 2'b11;
         step();
         pmv[0] = dut.pm[0]; pmv[1] = dut.pm[1]; pmv[2] = dut.pm[2]; pmv[3] = dut.pm[3];
         mn = 255; mx = 0;
         for (int s = 0; s < 4; s++) begin
            if (int'(pmv[s]) < mn) mn = int'(pmv[s]);
            if (int'(pmv[s]) > mx) mx = int'(pmv[s]);
         end
         check("norm_min_zero", mn, 0);
         check("norm_max_bound", int'(mx <= 40), 1);
      end
      direct = 1'b0; dec_en_drv = 1'b0;

      // streams through the channel register
      run_loop(1'b0, 1'b0, "clean");

      // mid-stream reset: build non-zero outputs first
      for (int i = 0; i < 40; i++) drive_bit(1'b1);
      check("pre_rst_enc_d", int'(enc_d_o), 2);
      check("pre_rst_dec_d", int'(dec_d_o), 1);
      check("pre_rst_dec_valid", int'(dec_valid_o), 1);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_enc_d", int'(enc_d_o), 0);
      check("mid_rst_enc_valid", int'(enc_valid_o), 0);
      check("mid_rst_dec_d", int'(dec_d_o), 0);
      check("mid_rst_dec_valid", int'(dec_valid_o), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive_bit(1'b0);
      check("post_rst_first_sym", int'(enc_d_o), 0);
      drive_bit(1'b1);
      check("post_rst_second_sym", int'(enc_d_o), 3);
      idle(2);

      run_loop(1'b1, 1'b0, "burst");
      run_loop(1'b0, 1'b1, "gaps");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
